// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, GRANT, GAP)
//   REQ_*         : requester index assignments on the shared SPI pins
//   idx_width()   : bit width needed to index n items (never below 1)
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int REQ_LCD   = 0;
  localparam int REQ_PSRAM = 1;
  localparam int REQ_FLASH = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Combinational round-robin search.
//   req        : per-requester request levels
//   last_owner : index of the previous owner; the search starts just above it
//   valid      : at least one request is pending
//   idx        : first requesting index after last_owner, wrapping upward
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    // Walk from the farthest candidate to the nearest one so the nearest
    // requester above last_owner is the final (winning) assignment.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last_owner) + off) % NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI pin set between NUM_REQ masters.
//   req / gnt                : per-master level request, one-hot-or-zero grant
//   m_spi_clk/mosi/ncs       : per-master SPI outputs, forwarded when granted
//   m_spi_miso               : pad MISO broadcast to every master (combinational)
//   spi_clk/spi_mosi/spi_miso: shared pads
//   cs_n                     : pad chip-selects, index-matched to requesters
//   busy                     : FSM is not idle
//   owner                    : current or most recent owner index
// Pads are registered so they change only on clk edges; a GAP of
// GAP_CYCLES with all CS high separates consecutive owners. With
// MAX_HOLD != 0 an owner is preempted between transactions once it has
// held the bus MAX_HOLD cycles while another master waits.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_HOLD   = 0,
  parameter int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] m_spi_clk,
  input  logic [NUM_REQ-1:0] m_spi_mosi,
  input  logic [NUM_REQ-1:0] m_spi_ncs,
  output logic               m_spi_miso,
  output logic               spi_clk,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic [NUM_REQ-1:0] cs_n,
  output logic               busy,
  output logic [IDX_W-1:0]   owner
);

  localparam int HOLD_W = idx_width(MAX_HOLD + 1);
  localparam int GAP_W  = idx_width(GAP_CYCLES);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                spi_clk_q, spi_clk_d;
  logic                spi_mosi_q, spi_mosi_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic                busy_q, busy_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                others_req;
  logic                preempt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // gnt_q is one-hot on the owner while in GRANT, so masking it out
  // leaves only the waiting masters.
  assign others_req = |(req & ~gnt_q);

  // Preempt only between transactions: the owner's CS intent must be high.
  assign preempt = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_W'(MAX_HOLD)) &&
                   others_req && m_spi_ncs[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    spi_clk_d    = 1'b0;
    spi_mosi_d   = 1'b0;
    cs_n_d       = '1;

    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        gnt_d      = '0;
        if (pick_valid) begin
          owner_d         = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          state_d         = GRANT;
        end
      end

      GRANT: begin
        spi_clk_d       = m_spi_clk[owner_q];
        spi_mosi_d      = m_spi_mosi[owner_q];
        cs_n_d[owner_q] = m_spi_ncs[owner_q];
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        // A release with CS still low is a protocol violation; the pads
        // are forced idle from the next registered update in GAP anyway.
        if (!req[owner_q] || preempt) begin
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      spi_clk_q    <= 1'b0;
      spi_mosi_q   <= 1'b0;
      cs_n_q       <= '1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      spi_clk_q    <= spi_clk_d;
      spi_mosi_q   <= spi_mosi_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign spi_clk    = spi_clk_q;
  assign spi_mosi   = spi_mosi_q;
  assign cs_n       = cs_n_q;
  assign m_spi_miso = spi_miso;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (GAP_CYCLES = 4, MAX_HOLD = 16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int NUM_REQ    = 3;
  localparam int GAP_CYCLES = 4;
  localparam int MAX_HOLD   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] m_spi_clk;
  logic [NUM_REQ-1:0] m_spi_mosi;
  logic [NUM_REQ-1:0] m_spi_ncs;
  logic               m_spi_miso;
  logic               spi_clk;
  logic               spi_mosi;
  logic               spi_miso;
  logic [NUM_REQ-1:0] cs_n;
  logic               busy;
  logic [1:0]         owner;

  int vectors     = 0;
  int miscompares = 0;

  spi_bus_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .m_spi_clk  (m_spi_clk),
    .m_spi_mosi (m_spi_mosi),
    .m_spi_ncs  (m_spi_ncs),
    .m_spi_miso (m_spi_miso),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .cs_n       (cs_n),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until some grant is seen; idle = clock periods spent with gnt low.
  task automatic wait_grant(output int idle, output bit ok);
    idle = 0;
    ok   = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (gnt != '0) ok = 1'b1;
      else begin
        step();
        idle++;
      end
    end
  endtask

  task automatic test_reset();
    req = '0; m_spi_clk = '0; m_spi_mosi = '0; m_spi_ncs = '1; spi_miso = 1'b0;
    #12;
    vectors++;
    if ({gnt, cs_n, spi_clk, spi_mosi, busy, owner} !== {3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b cs_n=%b clk=%b mosi=%b busy=%b owner=%0d, want 000 111 0 0 0 0",
               gnt, cs_n, spi_clk, spi_mosi, busy, owner);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    int idle;
    bit ok;
    int who;
    int exp_order[4] = '{REQ_LCD, REQ_PSRAM, REQ_FLASH, REQ_LCD};
    logic [2:0] exp_cs;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idle, ok);
      vectors++;
      if (!ok || gnt !== (3'b001 << exp_order[k]) || owner !== 2'(exp_order[k])) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: gnt=%b owner=%0d, want owner %0d", k, gnt, owner, exp_order[k]);
      end
      if (k > 0) begin
        vectors++;
        if (idle < GAP_CYCLES + 1) begin
          miscompares++;
          $display("FAIL rr_gap[%0d]: idle=%0d cycles, want >= %0d", k, idle, GAP_CYCLES + 1);
        end
      end
      who = exp_order[k];
      for (int c = 0; c < 10; c++) begin
        m_spi_ncs[who] = !(c >= 1 && c < 8);
        m_spi_clk[who] = (c >= 2 && c < 7) ? c[0] : 1'b0;
        step();
        exp_cs = 3'b111;
        exp_cs[who] = m_spi_ncs[who];
        vectors++;
        if ({gnt, cs_n} !== {3'b001 << who, exp_cs}) begin
          miscompares++;
          $display("FAIL rr_hold[%0d.%0d]: gnt=%b cs_n=%b, want %b %b", k, c, gnt, cs_n, 3'b001 << who, exp_cs);
        end
      end
      m_spi_ncs[who] = 1'b1;
      m_spi_clk[who] = 1'b0;
      req[who] = 1'b0;
      step();
      req[who] = 1'b1;
      vectors++;
      if ({gnt, cs_n} !== {3'b000, 3'b111}) begin
        miscompares++;
        $display("FAIL rr_release[%0d]: gnt=%b cs_n=%b, want 000 111", k, gnt, cs_n);
      end
    end
    req = '0;
  endtask

  task automatic test_single_request();
    repeat (8) step();
    req = 3'b001;
    spi_miso = 1'b1;
    #1;
    vectors++;
    if (m_spi_miso !== 1'b1) begin
      miscompares++;
      $display("FAIL miso_high: m_spi_miso=%b, want 1", m_spi_miso);
    end
    spi_miso = 1'b0;
    #1;
    vectors++;
    if (m_spi_miso !== 1'b0) begin
      miscompares++;
      $display("FAIL miso_low: m_spi_miso=%b, want 0", m_spi_miso);
    end
    step();
    vectors++;
    if ({gnt, busy, owner, cs_n} !== {3'b001, 1'b1, 2'd0, 3'b111}) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%b busy=%b owner=%0d cs_n=%b, want 001 1 0 111", gnt, busy, owner, cs_n);
    end
    // Master 2 misbehaves while ungranted; its clock must not reach the pad.
    m_spi_ncs[0] = 1'b0; m_spi_clk[0] = 1'b1; m_spi_mosi[0] = 1'b1; m_spi_clk[2] = 1'b1;
    step();
    vectors++;
    if ({cs_n, spi_clk, spi_mosi} !== {3'b110, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_pads_hi: cs_n=%b clk=%b mosi=%b, want 110 1 1", cs_n, spi_clk, spi_mosi);
    end
    m_spi_clk[0] = 1'b0; m_spi_mosi[0] = 1'b0;
    step();
    vectors++;
    if ({cs_n, spi_clk, spi_mosi} !== {3'b110, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_pads_lo: cs_n=%b clk=%b mosi=%b, want 110 0 0", cs_n, spi_clk, spi_mosi);
    end
    m_spi_clk[2] = 1'b0;
    m_spi_ncs[0] = 1'b1;
    step();
    vectors++;
    if (cs_n !== 3'b111) begin
      miscompares++;
      $display("FAIL single_cs_release: cs_n=%b, want 111", cs_n);
    end
    req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({gnt, busy, cs_n} !== {3'b000, 1'b1, 3'b111}) begin
        miscompares++;
        $display("FAIL single_gap[%0d]: gnt=%b busy=%b cs_n=%b, want 000 1 111", i, gnt, busy, cs_n);
      end
    end
    step();
    vectors++;
    if ({busy, owner, cs_n} !== {1'b0, 2'd0, 3'b111}) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b owner=%0d cs_n=%b, want 0 0 111", busy, owner, cs_n);
    end
  endtask

  task automatic test_preemption();
    int idle;
    bit ok;
    logic [2:0] exp_gnt;
    repeat (4) step();
    req = 3'b001;
    step();
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL preempt_grant0: gnt=%b, want 001", gnt);
    end
    // ncs low for 8, high for 4; first high window with hold >= 16 is t = 20.
    for (int t = 0; t <= 20; t++) begin
      m_spi_ncs[0] = ((t % 12) >= 8);
      req[1] = (t >= 5);
      step();
      exp_gnt = (t < 20) ? 3'b001 : 3'b000;
      vectors++;
      if ({gnt, cs_n} !== {exp_gnt, 2'b11, m_spi_ncs[0]}) begin
        miscompares++;
        $display("FAIL preempt[t=%0d]: gnt=%b cs_n=%b, want %b 11%b", t, gnt, cs_n, exp_gnt, m_spi_ncs[0]);
      end
    end
    m_spi_ncs[0] = 1'b1;
    wait_grant(idle, ok);
    vectors++;
    if (!ok || gnt !== 3'b010 || idle < GAP_CYCLES + 1) begin
      miscompares++;
      $display("FAIL preempt_handover: gnt=%b idle=%0d, want 010 after >= %0d idle", gnt, idle, GAP_CYCLES + 1);
    end
    req[0] = 1'b0;
  endtask

  task automatic test_violation();
    m_spi_ncs[1] = 1'b0;
    step();
    vectors++;
    if (cs_n !== 3'b101) begin
      miscompares++;
      $display("FAIL viol_cs_low: cs_n=%b, want 101", cs_n);
    end
    req[1] = 1'b0;
    step();
    vectors++;
    if ({gnt, cs_n, busy} !== {3'b000, 3'b101, 1'b1}) begin
      miscompares++;
      $display("FAIL viol_edge1: gnt=%b cs_n=%b busy=%b, want 000 101 1", gnt, cs_n, busy);
    end
    step();
    vectors++;
    if ({cs_n, busy} !== {3'b111, 1'b1}) begin
      miscompares++;
      $display("FAIL viol_cut: cs_n=%b busy=%b, want 111 1", cs_n, busy);
    end
    m_spi_ncs[1] = 1'b1;
    repeat (3) step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL viol_gap_end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int idle;
    bit ok;
    req = 3'b100;
    wait_grant(idle, ok);
    vectors++;
    if (!ok || gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid_grant: gnt=%b, want 100", gnt);
    end
    m_spi_ncs[2] = 1'b0; m_spi_clk[2] = 1'b1; m_spi_mosi[2] = 1'b1;
    step();
    vectors++;
    if ({cs_n, spi_clk, spi_mosi} !== {3'b011, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_mid_active: cs_n=%b clk=%b mosi=%b, want 011 1 1", cs_n, spi_clk, spi_mosi);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, cs_n, spi_clk, spi_mosi, busy, owner} !== {3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_async: gnt=%b cs_n=%b clk=%b mosi=%b busy=%b owner=%0d, want 000 111 0 0 0 0",
               gnt, cs_n, spi_clk, spi_mosi, busy, owner);
    end
    m_spi_ncs = '1; m_spi_clk = '0; m_spi_mosi = '0;
    req = 3'b111;
    #3;
    rst_n = 1'b1;
    wait_grant(idle, ok);
    vectors++;
    if (!ok || gnt !== 3'b001 || owner !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_first: gnt=%b owner=%0d, want 001 0", gnt, owner);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_request();
    test_preemption();
    test_violation();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100 us");
    $fatal(1, "watchdog expired");
  end

endmodule
